// File: rtl/booth_seq_divider_pkg.sv
// Shared definitions for the Booth arithmetic datapath: default operand width
// and the divider's FSM state encodings.
package booth_seq_divider_pkg;

  localparam int BOOTH_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREP = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

endpackage

// File: rtl/booth_seq_divider_twos_abs.sv
// Combinational two's-complement magnitude with sign-out. The most negative
// input maps to 2^(N-1), which is still representable as an unsigned N-bit value.
module booth_twos_abs #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_val,
  output logic [N-1:0] o_mag,
  output logic         o_neg
);

  assign o_neg = i_val[N-1];
  assign o_mag = o_neg ? -i_val : i_val;

endmodule

// File: rtl/booth_seq_divider.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit
// per clock, sign fix-up and range check at the end. Inverse of the Booth multiplier.
module booth_seq_divider
  import booth_seq_divider_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] Q_POS_LIM = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_NEG_LIM = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_dividend;
  logic [WIDTH-1:0]     r_divisor;
  logic                 r_neg_dvd;
  logic                 r_neg_q;
  logic                 r_err_pend;
  logic [WIDTH:0]       r_abs_dvs;
  logic [WIDTH:0]       r_p;
  logic [WIDTH-1:0]     r_q;
  logic                 r_done;
  logic                 r_err;
  logic [WIDTH-1:0]     r_quotient;
  logic [WIDTH-1:0]     r_remainder;

  logic [2*WIDTH-1:0]   w_abs_dvd;
  logic                 w_neg_dvd;
  logic [WIDTH-1:0]     w_abs_dvs;
  logic                 w_neg_dvs;
  logic [WIDTH+1:0]     w_shift;
  logic [WIDTH+1:0]     w_diff;
  logic                 w_q_ovf;
  logic                 w_err_fix;

  booth_twos_abs #(.N(2*WIDTH)) u_abs_dvd (
    .i_val (r_dividend),
    .o_mag (w_abs_dvd),
    .o_neg (w_neg_dvd)
  );

  booth_twos_abs #(.N(WIDTH)) u_abs_dvs (
    .i_val (r_divisor),
    .o_mag (w_abs_dvs),
    .o_neg (w_neg_dvs)
  );

  // With no pending error P < |divisor|, so the trial difference stays in signed
  // range and its top bit is a valid "went negative" flag.
  assign w_shift   = {r_p, r_q[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_abs_dvs};
  assign w_q_ovf   = r_neg_q ? (r_q > Q_NEG_LIM) : (r_q > Q_POS_LIM);
  assign w_err_fix = r_err_pend | w_q_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_neg_dvd   <= 1'b0;
      r_neg_q     <= 1'b0;
      r_err_pend  <= 1'b0;
      r_abs_dvs   <= '0;
      r_p         <= '0;
      r_q         <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_dividend <= dividend;
            r_divisor  <= divisor;
            r_state    <= ST_PREP;
          end
        end
        ST_PREP: begin
          r_neg_dvd  <= w_neg_dvd;
          r_neg_q    <= w_neg_dvd ^ w_neg_dvs;
          r_abs_dvs  <= {1'b0, w_abs_dvs};
          r_p        <= {1'b0, w_abs_dvd[2*WIDTH-1:WIDTH]};
          r_q        <= w_abs_dvd[WIDTH-1:0];
          // Upper half >= |divisor| means the quotient needs more than WIDTH bits.
          r_err_pend <= (r_divisor == '0) || (w_abs_dvd[2*WIDTH-1:WIDTH] >= w_abs_dvs);
          r_cnt      <= CW'(WIDTH-1);
          r_state    <= ST_DIV;
        end
        ST_DIV: begin
          if (!w_diff[WIDTH+1]) begin
            r_p <= w_diff[WIDTH:0];
            r_q <= {r_q[WIDTH-2:0], 1'b1};
          end else begin
            r_p <= w_shift[WIDTH:0];
            r_q <= {r_q[WIDTH-2:0], 1'b0};
          end
          if (r_cnt == '0) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_FIX: begin
          r_err       <= w_err_fix;
          r_quotient  <= w_err_fix ? '0 : (r_neg_q ? -r_q : r_q);
          r_remainder <= w_err_fix ? '0 : (r_neg_dvd ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0]);
          r_done      <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule
